// File: rtl/sweep_accumulator.sv
// Point-by-point ADC accumulator over MEASURES triggered sweeps, with sweep/block
// timing counters, a double-buffered snapshot and Stokes/anti-Stokes channel alternation.
module sweep_accumulator #(
  parameter int POINTS   = 1000,
  parameter int MEASURES = 65536,
  parameter int TAIL     = 128,
  parameter int ADC_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig,
  input  logic [ADC_W-1:0]      adc_data,
  output logic [29*POINTS-1:0]  sum,
  output logic                  switch,
  output logic                  opt_sw,
  output logic [10:0]           cnt_point,
  output logic [16:0]           cnt_measure,
  output logic [3:0]            cnt_save,
  output logic                  block_done,
  output logic                  trig_miss,
  output logic                  busy
);

  localparam int ACC_W = 29;
  localparam int IDX_W = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam logic [10:0] P_LAST = 11'(POINTS - 1);
  localparam logic [10:0] T_LAST = 11'(POINTS + TAIL - 1);
  localparam logic [10:0] PARK   = 11'(POINTS + TAIL);
  localparam logic [16:0] M_LAST = 17'(MEASURES - 1);

  // state   | meaning
  // S_IDLE  | parked, cnt_point = POINTS+TAIL, waiting for trig
  // S_SWEEP | accumulating one sample per cycle into acc[cnt_point]
  // S_TAIL  | idle slots after the last point, no accumulation
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_TAIL} state_t;

  state_t            state, state_nxt;
  logic              tail_exit;
  logic              block_end;
  logic [IDX_W-1:0]  acc_idx;
  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  acc [POINTS];

  assign acc_idx    = cnt_point[IDX_W-1:0];
  assign sample_ext = {{(ACC_W-ADC_W){1'b0}}, adc_data};
  assign block_end  = tail_exit && (cnt_measure == M_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // TAIL must be at least 1 so the last point is written before the snapshot copy.
  always_comb begin
    state_nxt = state;
    tail_exit = 1'b0;
    case (state)
      S_IDLE:  if (trig) state_nxt = S_SWEEP;
      S_SWEEP: if (cnt_point == P_LAST) state_nxt = S_TAIL;
      S_TAIL: begin
        if (cnt_point == T_LAST) begin
          state_nxt = S_IDLE;
          tail_exit = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_point   <= PARK;
      cnt_measure <= '0;
      cnt_save    <= '0;
      sum         <= '0;
      switch      <= 1'b0;
      opt_sw      <= 1'b0;
      block_done  <= 1'b0;
      trig_miss   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      trig_miss  <= trig && (state != S_IDLE);
      block_done <= block_end;
      if (state == S_IDLE) cnt_point <= trig ? 11'd0 : PARK;
      else                 cnt_point <= cnt_point + 11'd1;
      if (tail_exit) cnt_measure <= block_end ? 17'd0 : cnt_measure + 17'd1;
      if (block_end) begin
        for (int k = 0; k < POINTS; k++) sum[ACC_W*k +: ACC_W] <= acc[k];
        switch   <= opt_sw;
        opt_sw   <= ~opt_sw;
        cnt_save <= cnt_save + 4'd1;
      end
    end
  end

  // First sweep of a block loads instead of adding, so no clear pass is needed.
  always_ff @(posedge clk) begin
    if (!rst && state == S_SWEEP)
      acc[acc_idx] <= ((cnt_measure == 17'd0) ? '0 : acc[acc_idx]) + sample_ext;
  end

endmodule

// File: tb/tb_sweep_accumulator.sv
// Directed bench for sweep_accumulator: POINTS=4/MEASURES=3/TAIL=8 main instance,
// plus a POINTS=2/MEASURES=1/TAIL=1 instance for per-sweep blocks and cnt_save wrap.
module tb_sweep_accumulator;

  localparam int P = 4, M = 3, T = 8;
  localparam int P2 = 2, T2 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0, trig2 = 1'b0;
  logic [11:0] adc = '0, adc2 = '0;

  logic [29*P-1:0]  sum;
  logic [29*P2-1:0] sum2;
  logic switch, opt_sw, block_done, trig_miss, busy;
  logic switch2, opt_sw2, block_done2, trig_miss2, busy2;
  logic [10:0] cnt_point, cnt_point2;
  logic [16:0] cnt_measure, cnt_measure2;
  logic [3:0]  cnt_save, cnt_save2;

  int n_checks = 0;
  int n_errors = 0;

  int exp_sum [P];
  logic exp_sw, exp_opt;
  int exp_save;

  always #5 clk = ~clk;

  sweep_accumulator #(.POINTS(P), .MEASURES(M), .TAIL(T), .ADC_W(12)) dut (
    .clk(clk), .rst(rst), .trig(trig), .adc_data(adc), .sum(sum), .switch(switch),
    .opt_sw(opt_sw), .cnt_point(cnt_point), .cnt_measure(cnt_measure), .cnt_save(cnt_save),
    .block_done(block_done), .trig_miss(trig_miss), .busy(busy)
  );

  sweep_accumulator #(.POINTS(P2), .MEASURES(1), .TAIL(T2), .ADC_W(12)) dut1 (
    .clk(clk), .rst(rst), .trig(trig2), .adc_data(adc2), .sum(sum2), .switch(switch2),
    .opt_sw(opt_sw2), .cnt_point(cnt_point2), .cnt_measure(cnt_measure2), .cnt_save(cnt_save2),
    .block_done(block_done2), .trig_miss(trig_miss2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sample(input int mode, input int m, input int p);
    case (mode)
      0:       return 10*m + p;
      1:       return 4095;
      default: return 100 + 10*m + p;
    endcase
  endfunction

  task automatic check_snapshot(input string tag);
    for (int k = 0; k < P; k++) check({tag, "_sum"}, sum[29*k +: 29], exp_sum[k]);
    check({tag, "_switch"}, switch, exp_sw);
    check({tag, "_opt_sw"}, opt_sw, exp_opt);
    check({tag, "_cnt_save"}, cnt_save, exp_save);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnt_point"}, cnt_point, P + T);
    check({tag, "_cnt_measure"}, cnt_measure, 0);
    check({tag, "_cnt_save"}, cnt_save, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_switch"}, switch, 0);
    check({tag, "_opt_sw"}, opt_sw, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_block_done"}, block_done, 0);
    check({tag, "_trig_miss"}, trig_miss, 0);
  endtask

  // One full block of M sweeps; misses are cnt_point values at which a stray trig is pulsed.
  task automatic run_block(input int mode, input int miss_a, input int miss_b,
                           input int e0, input int e1, input int e2, input int e3);
    for (int m = 0; m < M; m++) begin
      check_snapshot("pre_sweep");
      check("park", cnt_point, P + T);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < P + T; i++) begin
        check("cnt_point", cnt_point, i);
        check("busy", busy, 1);
        check("cnt_measure", cnt_measure, m);
        check("trig_miss", trig_miss, (i > 0) && ((i-1 == miss_a) || (i-1 == miss_b)));
        check("sum_hold", sum[28:0], exp_sum[0]);
        check("block_done_mid", block_done, 0);
        trig = (i == miss_a) || (i == miss_b);
        adc  = (i < P) ? 12'(sample(mode, m, i)) : 12'd7;
        tick();
      end
      trig = 1'b0;
      check("end_park", cnt_point, P + T);
      check("end_busy", busy, 0);
      check("end_cnt_measure", cnt_measure, (m + 1) % M);
      check("end_block_done", block_done, m == M - 1);
      if (m == M - 1) begin
        exp_sum[0] = e0; exp_sum[1] = e1; exp_sum[2] = e2; exp_sum[3] = e3;
        exp_sw   = exp_opt;
        exp_opt  = ~exp_opt;
        exp_save = (exp_save + 1) % 16;
        check_snapshot("block_end");
      end
      tick();
      check("block_done_once", block_done, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < P; k++) exp_sum[k] = 0;
    exp_sw = 0; exp_opt = 0; exp_save = 0;

    rst = 1'b1;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_reset_state("idle");

    // Block 1: 10m+p; block 2: full-scale, no carry; block 3: same as 1 with stray triggers
    run_block(0, 99, 99, 30, 33, 36, 39);
    run_block(1, 99, 99, 12285, 12285, 12285, 12285);
    run_block(0, 2, 9, 30, 33, 36, 39);

    // Abort mid-block: sweep 0 done, reset at cnt_measure=1, cnt_point=3
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < P + T; i++) begin adc = 12'd4095; tick(); end
    tick();
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 3; i++) begin adc = 12'd4095; tick(); end
    check("abort_cnt_measure", cnt_measure, 1);
    check("abort_cnt_point", cnt_point, 3);
    rst = 1'b1;
    tick();
    check_reset_state("abort");
    rst = 1'b0;
    tick();
    for (int k = 0; k < P; k++) exp_sum[k] = 0;
    exp_sw = 0; exp_opt = 0; exp_save = 0;
    run_block(2, 99, 99, 330, 333, 336, 339);

    // MEASURES=1 instance: each sweep is a block, loaded not added
    for (int b = 0; b < 17; b++) begin
      trig2 = 1'b1; tick(); trig2 = 1'b0;
      for (int i = 0; i < P2 + T2; i++) begin
        check("m1_cnt_point", cnt_point2, i);
        adc2 = (i < P2) ? 12'(5*b + i + 1) : 12'd9;
        tick();
      end
      check("m1_park", cnt_point2, P2 + T2);
      check("m1_block_done", block_done2, 1);
      check("m1_cnt_measure", cnt_measure2, 0);
      check("m1_sum0", sum2[28:0], 5*b + 1);
      check("m1_sum1", sum2[57:29], 5*b + 2);
      check("m1_switch", switch2, b % 2);
      check("m1_opt_sw", opt_sw2, (b + 1) % 2);
      check("m1_cnt_save", cnt_save2, (b + 1) % 16);
      tick();
      check("m1_block_done_once", block_done2, 0);
    end
    check("m1_wrap_final", cnt_save2, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
